// File: rtl/ext_link_peer_if.sv
// Link-side and local-handshake signals of ext_link_peer, bundled for port use.
// master is the peer itself; slave is the local logic plus the far end of the line.
interface ext_link_peer_if;
    logic        tx;
    logic        rx;
    logic [9:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic [15:0] rx_baud;
    logic        link_err;

    modport master (
        output tx, tx_busy, tx_done, rx_data, rx_valid, rx_baud, link_err,
        input  rx, tx_data, tx_start
    );

    modport slave (
        input  tx, tx_busy, tx_done, rx_data, rx_valid, rx_baud, link_err,
        output rx, tx_data, tx_start
    );
endinterface

// File: rtl/ext_link_peer.sv
// Far-end peer of the external serial link: half-duplex frame initiator/responder on tx/rx.
// Optional ack watchdog and sticky link_err are enabled by defining LINK_TIMEOUT_EN.
module ext_link_peer #(
    parameter logic [15:0] BAUD_SIZE = 16'd8,
    parameter logic [15:0] MIN_PULSE = 16'd2
`ifdef LINK_TIMEOUT_EN
    ,
    parameter logic [19:0] TIMEOUT   = 20'd100000
`endif
) (
    input  logic           clk,
    input  logic           rstn,
    ext_link_peer_if.master link
);

    typedef enum logic [4:0] {
        IDLE,
        T_BAUD,
        T_ACK1_LO,
        T_ACK1_HI,
        T_GAP,
        T_BITS,
        T_ACK2_LO,
        T_ACK2_HI,
        R_MEASURE,
        R_WAIT,
        R_ACK,
        R_START,
        R_HALF,
        R_SAMPLE,
        R_TAIL,
        R_TACK
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  bit_idx, bit_idx_n;
    logic [9:0]  frame, frame_n;
    logic [9:0]  shift, shift_n;
    logic [9:0]  rx_data_q, rx_data_n;
    logic [15:0] baud, baud_n;
    logic        tx_q, tx_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic        valid, valid_n;
`ifdef LINK_TIMEOUT_EN
    logic [19:0] wdog, wdog_n;
    logic        err, err_n;
    logic        ack_wait;
`endif

    // rx is assumed to already be synchronous to clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            bit_idx   <= 4'd0;
            frame     <= 10'd0;
            shift     <= 10'd0;
            rx_data_q <= 10'd0;
            baud      <= 16'd0;
            tx_q      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
`ifdef LINK_TIMEOUT_EN
            wdog      <= 20'd0;
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            frame     <= frame_n;
            shift     <= shift_n;
            rx_data_q <= rx_data_n;
            baud      <= baud_n;
            tx_q      <= tx_n;
            busy      <= busy_n;
            done      <= done_n;
            valid     <= valid_n;
`ifdef LINK_TIMEOUT_EN
            wdog      <= wdog_n;
            err       <= err_n;
`endif
        end
    end

    // Every timed state counts cnt from 1 on entry and acts when it reaches its target.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        frame_n   = frame;
        shift_n   = shift;
        rx_data_n = rx_data_q;
        baud_n    = baud;
        tx_n      = tx_q;
        busy_n    = busy;
        done_n    = 1'b0;
        valid_n   = 1'b0;
`ifdef LINK_TIMEOUT_EN
        wdog_n    = 20'd1;
        err_n     = err;
`endif

        case (state)
            IDLE: begin
                if (!link.rx) begin
                    cnt_n   = 16'd1;
                    state_n = R_MEASURE;
                end else if (link.tx_start) begin
                    frame_n = link.tx_data;
                    busy_n  = 1'b1;
                    tx_n    = 1'b0;
                    cnt_n   = 16'd1;
                    state_n = T_BAUD;
`ifdef LINK_TIMEOUT_EN
                    err_n   = 1'b0;
`endif
                end
            end
            T_BAUD: begin
                if (cnt == BAUD_SIZE) begin
                    tx_n    = 1'b1;
                    state_n = T_ACK1_LO;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            T_ACK1_LO: if (!link.rx) state_n = T_ACK1_HI;
            T_ACK1_HI: begin
                if (link.rx) begin
                    cnt_n   = 16'd1;
                    state_n = T_GAP;
                end
            end
            T_GAP: begin
                if (cnt == BAUD_SIZE) begin
                    tx_n      = 1'b0;
                    cnt_n     = 16'd1;
                    bit_idx_n = 4'd10;
                    state_n   = T_BITS;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            // bit_idx 10 is the start-bit slot; slot k below it carries frame[k].
            T_BITS: begin
                if (cnt == BAUD_SIZE) begin
                    cnt_n = 16'd1;
                    if (bit_idx == 4'd0) begin
                        tx_n    = 1'b1;
                        state_n = T_ACK2_LO;
                    end else begin
                        tx_n      = frame[bit_idx - 4'd1];
                        bit_idx_n = bit_idx - 4'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            T_ACK2_LO: if (!link.rx) state_n = T_ACK2_HI;
            T_ACK2_HI: begin
                if (link.rx) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            R_MEASURE: begin
                if (!link.rx) begin
                    if (cnt != 16'hFFFF) cnt_n = cnt + 16'd1;
                end else if (cnt < MIN_PULSE) begin
                    state_n = IDLE;
                end else begin
                    baud_n  = cnt;
                    cnt_n   = 16'd1;
                    state_n = R_WAIT;
                end
            end
            R_WAIT: begin
                if (cnt == baud) begin
                    tx_n    = 1'b0;
                    cnt_n   = 16'd1;
                    state_n = R_ACK;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            R_ACK: begin
                if (cnt == baud) begin
                    tx_n    = 1'b1;
                    state_n = R_START;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            R_START: begin
                if (!link.rx) begin
                    cnt_n   = 16'd1;
                    state_n = R_HALF;
                end
            end
            R_HALF: begin
                if (cnt >= (baud >> 1)) begin
                    cnt_n     = 16'd1;
                    bit_idx_n = 4'd9;
                    state_n   = R_SAMPLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            R_SAMPLE: begin
                if (cnt == baud) begin
                    shift_n[bit_idx] = link.rx;
                    cnt_n            = 16'd1;
                    if (bit_idx == 4'd0) begin
                        bit_idx_n = 4'd1;
                        state_n   = R_TAIL;
                    end else begin
                        bit_idx_n = bit_idx - 4'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            // Two back-to-back baud periods keep cnt within 16 bits for the 2*N tail.
            R_TAIL: begin
                if (cnt == baud) begin
                    cnt_n = 16'd1;
                    if (bit_idx == 4'd0) begin
                        tx_n    = 1'b0;
                        state_n = R_TACK;
                    end else begin
                        bit_idx_n = bit_idx - 4'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            R_TACK: begin
                if (cnt == baud) begin
                    tx_n      = 1'b1;
                    rx_data_n = shift;
                    valid_n   = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef LINK_TIMEOUT_EN
        // The watchdog only runs while an ack-wait state is still waiting; any exit reloads it.
        if (ack_wait && (state_n == state)) begin
            if (wdog == TIMEOUT) begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                err_n   = 1'b1;
            end else begin
                wdog_n = wdog + 20'd1;
            end
        end
`endif
    end

`ifdef LINK_TIMEOUT_EN
    assign ack_wait = (state == T_ACK1_LO) || (state == T_ACK1_HI) ||
                      (state == T_ACK2_LO) || (state == T_ACK2_HI) ||
                      (state == R_START);
    assign link.link_err = err;
`else
    assign link.link_err = 1'b0;
`endif

    assign link.tx       = tx_q;
    assign link.tx_busy  = busy;
    assign link.tx_done  = done;
    assign link.rx_data  = rx_data_q;
    assign link.rx_valid = valid;
    assign link.rx_baud  = baud;

endmodule

// File: doc/ext_link_peer.md
Name: ext_link_peer

Overview:
- Far-end partner of the board-level external serial link. It sits on the host/peer FPGA and drives the link's tx/rx pair against the bus-side external interface.
- Initiates outbound frames: baud pulse, ack wait, start bit, 10 data bits, ack wait.
- Responds to inbound frames: measures the baud pulse, acks, samples 10 bits, acks.
- Presents a simple parallel handshake to local logic.

Parameters:
BAUD_SIZE, 16'd8, clocks per bit for outbound frames; legal range 4..65535.
MIN_PULSE, 16'd2, inbound baud pulses shorter than this many clocks are discarded as glitches.
TIMEOUT, 20'd100000, clocks to wait for an ack pulse; used only with LINK_TIMEOUT_EN.

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
tx  output  1  link line toward the far end; idles high
rx  input  1  link line from the far end; idles high
tx_data  input  10  outbound frame, {2-bit prefix, 8-bit payload}
tx_start  input  1  one-cycle request to send tx_data
tx_busy  output  1  high from tx_start acceptance until the frame completes
tx_done  output  1  one-cycle pulse when the far-end final ack ends
rx_data  output  10  last inbound frame; held until the next frame
rx_valid  output  1  one-cycle pulse when rx_data updates
rx_baud  output  16  measured baud of the last inbound frame
link_err  output  1  sticky ack-timeout flag; cleared by the next accepted tx_start (LINK_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (asynchronous, active low): tx=1, tx_busy=0, tx_done=0, rx_valid=0, rx_data=0, rx_baud=0, link_err=0, state=IDLE, counters cleared.
- Reset mid-frame aborts immediately. tx returns high and no done/valid pulse is issued.
- Single shared FSM; the link is half-duplex.
- IDLE priorities:
  - rx==0 has priority. Enter R_MEASURE, cnt=1.
  - Otherwise tx_start: latch tx_data, tx_busy=1, drive tx=0, enter T_BAUD.
  - tx_start while busy is ignored. It is not queued.
- Outbound path (B=BAUD_SIZE):
  - T_BAUD: tx=0 for exactly B clocks, then tx=1. Go to T_ACK1_LO.
  - T_ACK1_LO: wait for rx==0, then T_ACK1_HI.
  - T_ACK1_HI: wait for rx==1, then T_GAP.
  - T_GAP: hold tx=1 for B clocks, then T_BITS.
  - T_BITS: start bit tx=0 for B clocks, then bits 9 down to 0 (MSB first), each held B clocks. Total 11*B clocks.
  - After the bits, tx=1 and go to T_ACK2_LO.
  - T_ACK2_LO / T_ACK2_HI: wait for the rx low then rx high edges.
  - On rx rising: tx_done=1 for one cycle, tx_busy=0, return to IDLE.
- Inbound path:
  - R_MEASURE: count clocks while rx==0. Count saturates at 16'hFFFF.
  - On rx==1 with count<MIN_PULSE: return to IDLE silently.
  - Otherwise N=count, latch rx_baud=N, enter R_WAIT.
  - R_WAIT: N clocks with tx=1, then tx=0 (ack).
  - R_ACK: tx=0 for N clocks, then tx=1. Enter R_START.
  - R_START: wait for rx==0, then wait floor(N/2) clocks (mid start bit).
  - R_SAMPLE: sample rx every N clocks, 10 times, into bits 9..0.
  - R_TAIL: after the 10th sample, wait 2*N clocks with tx=1, then tx=0 for N clocks (ack). tx returns to 1.
  - The cycle tx returns high: rx_data updated and rx_valid=1 for one cycle. Return to IDLE.
- Counters are 16-bit. Bit index is a 4-bit down-counter ending at 0; there is no wrap.
- Ack waits with no timeout hang indefinitely by design.

Optional Feature:
- LINK_TIMEOUT_EN defined:
  - Every ack-wait state (T_ACK1_LO/HI, T_ACK2_LO/HI, R_START) has a 20-bit watchdog that reloads on state entry.
  - Expiry after TIMEOUT clocks sets link_err=1, tx=1, tx_busy=0, returns to IDLE. No tx_done or rx_valid is issued.
- Undefined: no watchdog logic; link_err is constant 0.

Test Plan:
- BAUD_SIZE=8, tx_start with tx_data=10'h0A5 and a modelled far end acking 8 clocks low:
  - tx low exactly 8 clocks.
  - After ack, 8-clock gap, then the start bit and bits 0,0,1,0,1,0,0,1,0,1, each 8 clocks.
  - tx_done pulses once after the final ack; tx_busy is low on the following cycle.
- Inbound frame at N=16, payload 10'h3C2:
  - Ack low 16 clocks, starting 16 clocks after the baud pulse ends.
  - rx_baud=16, rx_data=10'h3C2, rx_valid is one pulse.
  - Second ack appears 32 clocks after the 10th sample.
- Inbound 1-clock rx low glitch (MIN_PULSE=2) -> FSM back in IDLE; tx stays 1, no rx_valid, rx_baud unchanged.
- rx falls in the same cycle as tx_start -> inbound path taken, tx_busy stays 0, tx_start dropped. A later tx_start sends normally.
- rstn asserted during T_BITS -> tx=1 immediately, tx_busy=0, no tx_done. The next frame after reset completes correctly.
- LINK_TIMEOUT_EN, TIMEOUT=200, far end never acks -> link_err=1 at 200 clocks after entering T_ACK1_LO, tx_busy=0. The next tx_start clears link_err.
